pipeline_ctrl: RTL and testbench

- Central hazard, forwarding and stall controller for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB). Replaces the stall-only hazard detector.
- Adds a parametrised operand forwarding unit (compile-time and runtime enable) and a memory wait-state FSM for multi-cycle SRAM (fixed-count or ready-handshake mode).
- Adds a saturating stall-cycle counter.
- Drives every pipeline-register freeze/flush/NOP control from one place.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/pipeline_ctrl_mem_wait.sv | 104 ++++++++++
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: operand-forward selects and
// memory wait-state FSM states.
package pipeline_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_WAIT = 2'b01,
        MS_DONE = 2'b10
    } mem_state_e;

endpackage

// File: rtl/pipeline_ctrl_mem_wait.sv
// Memory wait-state FSM: stalls the pipeline for a fixed count per access or
// until the SRAM signals ready, depending on WAIT_MODE.
module mem_wait_fsm
    import pipeline_ctrl_pkg::*;
#(
    parameter int WAIT_MODE = 0,
    parameter int MEM_WAIT  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_access,
    input  logic mem_ready,
    output logic mem_stall
);

    localparam int WCNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam int LOAD   = (MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0;
    localparam logic [WCNT_W-1:0] CNT_LOAD = WCNT_W'(LOAD);
    localparam logic [WCNT_W-1:0] CNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] CNT_ZERO = WCNT_W'(0);

    mem_state_e        state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic              stall_s;

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MS_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and raw stall. The IDLE cycle that sees the access
    // already stalls, so the counter holds the remaining MEM_WAIT-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_s = 1'b0;
        if (WAIT_MODE == 0) begin
            if (MEM_WAIT == 0) begin
                state_d = MS_IDLE;
                cnt_d   = CNT_ZERO;
            end else begin
                case (state_q)
                    MS_IDLE: begin
                        if (mem_access) begin
                            stall_s = 1'b1;
                            if (LOAD == 0) begin
                                state_d = MS_DONE;
                            end else begin
                                state_d = MS_WAIT;
                                cnt_d   = CNT_LOAD;
                            end
                        end else begin
                            state_d = MS_IDLE;
                        end
                    end
                    MS_WAIT: begin
                        stall_s = 1'b1;
                        if (cnt_q <= CNT_ONE) begin
                            state_d = MS_DONE;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    MS_DONE: state_d = MS_IDLE;
                    default: state_d = MS_IDLE;
                endcase
            end
        end else begin
            case (state_q)
                MS_IDLE: begin
                    stall_s = mem_access & ~mem_ready;
                    if (mem_access && mem_ready) begin
                        state_d = MS_DONE;
                    end else if (mem_access) begin
                        state_d = MS_WAIT;
                    end else begin
                        state_d = MS_IDLE;
                    end
                end
                MS_WAIT: begin
                    stall_s = mem_access & ~mem_ready;
                    if (mem_ready) begin
                        state_d = MS_DONE;
                    end else begin
                        state_d = MS_WAIT;
                    end
                end
                MS_DONE: state_d = MS_IDLE;
                default: state_d = MS_IDLE;
            endcase
        end
    end

    // Reset drops the stall at once so an abandoned access never freezes the pipe
    assign mem_stall = rst_n & stall_s;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard, forwarding and stall controller for the 5-stage pipeline;
// all freeze/flush/NOP controls are resolved here in one priority mux.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int FWD_EN     = 1,
    parameter int WAIT_MODE  = 0,
    parameter int MEM_WAIT   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fwd_mode,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_src1,
    input  logic [REG_ADDR_W-1:0] exe_src2,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_wb_en,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  pc_freeze,
    output logic                  if_id_freeze,
    output logic                  if_id_flush,
    output logic                  id_ex_nop,
    output logic                  back_freeze,
    output logic                  mem_stall,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic FWD_PRESENT = (FWD_EN != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             fwd_on_s;
    logic             hz_s;
    logic             id_hit_exe_s;
    logic             id_hit_mem_s;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    mem_wait_fsm #(
        .WAIT_MODE (WAIT_MODE),
        .MEM_WAIT  (MEM_WAIT)
    ) u_mem_wait (
        .clk        (clk),
        .rst_n      (rst),
        .mem_access (mem_r_en | mem_w_en),
        .mem_ready  (mem_ready),
        .mem_stall  (mem_stall)
    );

    assign fwd_on_s = FWD_PRESENT & fwd_mode;

    // Operand forwarding: MEM wins over WB; a load in MEM has no ALU result yet
    always_comb begin
        fwd_sel_a = FWD_REG;
        fwd_sel_b = FWD_REG;
        if (fwd_on_s) begin
            if (mem_wb_en && !mem_r_en && (mem_dest == exe_src1)) begin
                fwd_sel_a = FWD_MEM;
            end else if (wb_wb_en && (wb_dest == exe_src1)) begin
                fwd_sel_a = FWD_WB;
            end else begin
                fwd_sel_a = FWD_REG;
            end
            if (mem_wb_en && !mem_r_en && (mem_dest == exe_src2)) begin
                fwd_sel_b = FWD_MEM;
            end else if (wb_wb_en && (wb_dest == exe_src2)) begin
                fwd_sel_b = FWD_WB;
            end else begin
                fwd_sel_b = FWD_REG;
            end
        end else begin
            fwd_sel_a = FWD_REG;
            fwd_sel_b = FWD_REG;
        end
    end

    // Data hazard: full RAW check without forwarding, load-use only with it
    always_comb begin
        id_hit_exe_s = (id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest));
        id_hit_mem_s = (id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest));
        if (fwd_on_s) begin
            hz_s = exe_mem_r_en & exe_wb_en & id_hit_exe_s;
        end else begin
            hz_s = (exe_wb_en & id_hit_exe_s) | (mem_wb_en & id_hit_mem_s);
        end
    end

    // Priority mux: memory wait > taken branch > data hazard
    always_comb begin
        pc_freeze    = 1'b0;
        if_id_freeze = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_nop    = 1'b0;
        back_freeze  = 1'b0;
        if (mem_stall) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            back_freeze  = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_nop   = 1'b1;
        end else if (hz_s) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_ex_nop    = 1'b1;
        end else begin
            pc_freeze = 1'b0;
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_count_d = stall_count_q;
        if ((mem_stall || hz_s || branch_taken) && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one fixed-wait instance (MEM_WAIT=4) and
// one ready-handshake instance share the stimulus.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fwd_mode;
    logic [3:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
    logic       id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_r_en, mem_w_en;
    logic       wb_wb_en, mem_ready, branch_taken;

    logic [1:0]  a0_sel_a, a0_sel_b, a1_sel_a, a1_sel_b;
    logic        a0_pcf, a0_iff, a0_ifl, a0_nop, a0_bf, a0_ms;
    logic        a1_pcf, a1_iff, a1_ifl, a1_nop, a1_bf, a1_ms;
    logic [15:0] a0_cnt, a1_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.WAIT_MODE(0), .MEM_WAIT(4)) dut0 (
        .clk(clk), .rst(rst), .fwd_mode(fwd_mode),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .fwd_sel_a(a0_sel_a), .fwd_sel_b(a0_sel_b), .pc_freeze(a0_pcf), .if_id_freeze(a0_iff),
        .if_id_flush(a0_ifl), .id_ex_nop(a0_nop), .back_freeze(a0_bf), .mem_stall(a0_ms),
        .stall_count(a0_cnt)
    );

    pipeline_ctrl #(.WAIT_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .fwd_mode(fwd_mode),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .fwd_sel_a(a1_sel_a), .fwd_sel_b(a1_sel_b), .pc_freeze(a1_pcf), .if_id_freeze(a1_iff),
        .if_id_flush(a1_ifl), .id_ex_nop(a1_nop), .back_freeze(a1_bf), .mem_stall(a1_ms),
        .stall_count(a1_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fwd_mode = 1'b1;
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
        exe_src1 = 4'd0; exe_src2 = 4'd0; exe_dest = 4'd0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        wb_dest = 4'd0; wb_wb_en = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        clear_inputs();
        do_reset();
        #1;
        check_val("rst_cnt0", {16'd0, a0_cnt}, 32'd0);
        check_val("rst_ms0", {31'd0, a0_ms}, 32'd0);
        check_val("rst_ctrl0", {27'd0, a0_pcf, a0_iff, a0_ifl, a0_nop, a0_bf}, 32'd0);
        check_val("rst_sel0", {28'd0, a0_sel_a, a0_sel_b}, 32'd0);

        // Forwarding selects
        exe_src1 = 4'd3; mem_dest = 4'd3; mem_wb_en = 1'b1; wb_dest = 4'd3; wb_wb_en = 1'b1;
        #1 check_val("fwd_a_mem", {30'd0, a0_sel_a}, 32'd1);
        check_val("fwd_b_reg", {30'd0, a0_sel_b}, 32'd0);
        exe_src2 = 4'd3;
        #1 check_val("fwd_b_mem", {30'd0, a0_sel_b}, 32'd1);
        mem_wb_en = 1'b0;
        #1 check_val("fwd_a_wb", {30'd0, a0_sel_a}, 32'd2);
        mem_wb_en = 1'b1; mem_dest = 4'd7;
        #1 check_val("fwd_a_wb_nomatch", {30'd0, a0_sel_a}, 32'd2);
        fwd_mode = 1'b0;
        #1 check_val("fwd_off", {28'd0, a0_sel_a, a0_sel_b}, 32'd0);

        // Load-use stall with forwarding on
        clear_inputs();
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd5; id_src2 = 4'd5; id_two_src = 1'b1;
        #1 check_val("lu_stall", {27'd0, a0_pcf, a0_iff, a0_ifl, a0_nop, a0_bf}, 32'b11010);
        tick();
        check_val("lu_cnt", {16'd0, a0_cnt}, 32'd1);
        branch_taken = 1'b1;
        #1 check_val("br_over_hz", {27'd0, a0_pcf, a0_iff, a0_ifl, a0_nop, a0_bf}, 32'b00110);
        tick();
        branch_taken = 1'b0; id_two_src = 1'b0;
        #1 check_val("lu_one_src", {27'd0, a0_pcf, a0_iff, a0_ifl, a0_nop, a0_bf}, 32'd0);
        tick();
        check_val("lu_cnt2", {16'd0, a0_cnt}, 32'd2);

        // RAW hazard without forwarding, held two cycles
        clear_inputs();
        fwd_mode = 1'b0; mem_dest = 4'd2; mem_wb_en = 1'b1; id_src1 = 4'd2;
        for (int i = 0; i < 2; i++) begin
            #1 check_val("raw_stall", {27'd0, a0_pcf, a0_iff, a0_ifl, a0_nop, a0_bf}, 32'b11010);
            tick();
        end
        check_val("raw_cnt", {16'd0, a0_cnt}, 32'd4);

        // Fixed-wait loads held back-to-back: 4 stall, 1 done, 4 stall, 1 done
        clear_inputs();
        do_reset();
        mem_r_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1 check_val("fixed_ms", {31'd0, a0_ms}, ((i % 5) == 4) ? 32'd0 : 32'd1);
            check_val("fixed_bf", {31'd0, a0_bf}, ((i % 5) == 4) ? 32'd0 : 32'd1);
            tick();
            if (i == 4) check_val("fixed_cnt4", {16'd0, a0_cnt}, 32'd4);
        end
        check_val("fixed_cnt8", {16'd0, a0_cnt}, 32'd8);

        // Ready handshake: three wait cycles then ready
        clear_inputs();
        do_reset();
        mem_w_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_val("hs_ms", {31'd0, a1_ms}, 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        #1 check_val("hs_ready", {31'd0, a1_ms}, 32'd0);
        tick();
        mem_w_en = 1'b0; mem_ready = 1'b0;
        tick();
        check_val("hs_cnt", {16'd0, a1_cnt}, 32'd3);

        // Zero-wait completion
        do_reset();
        mem_w_en = 1'b1; mem_ready = 1'b1;
        #1 check_val("hs_zero", {31'd0, a1_ms}, 32'd0);
        tick();
        mem_w_en = 1'b0; mem_ready = 1'b0;
        tick();
        check_val("hs_zero_cnt", {16'd0, a1_cnt}, 32'd0);

        // Branch deferred behind a memory wait
        clear_inputs();
        do_reset();
        mem_r_en = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_val("ms_br", {27'd0, a0_pcf, a0_iff, a0_ifl, a0_nop, a0_bf}, 32'b11001);
            tick();
        end
        #1 check_val("br_release", {27'd0, a0_pcf, a0_iff, a0_ifl, a0_nop, a0_bf}, 32'b00110);
        tick();
        mem_r_en = 1'b0; branch_taken = 1'b0;
        check_val("br_cnt", {16'd0, a0_cnt}, 32'd5);

        // Reset in the middle of a wait abandons the access
        clear_inputs();
        do_reset();
        mem_r_en = 1'b1;
        tick();
        tick();
        check_val("mid_ms", {31'd0, a0_ms}, 32'd1);
        rst = 1'b0;
        #1 check_val("mid_rst_ms", {31'd0, a0_ms}, 32'd0);
        check_val("mid_rst_cnt", {16'd0, a0_cnt}, 32'd0);
        mem_r_en = 1'b0;
        tick();
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
